// File: rtl/shifter_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter_ctrl
// Brief    : Round-robin sharing of one 32-bit SLL barrel shifter between two
//            requesters, with a single tagged response channel.
//            Optional feature macro: SHIFT_SRL_EN (SRL via bit reversal).
// Revision : 1.0 - initial release
// ============================================================================
module shifter_arbiter_ctrl #(
  parameter int         DW        = 32,
  parameter logic [5:0] FUNCT_SLL = 6'h00,
  parameter logic [5:0] FUNCT_SRL = 6'h02,
  parameter logic       RR_INIT   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_data,
  input  logic [DW-1:0] req0_shamt,
  input  logic [5:0]    req0_funct,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_data,
  input  logic [DW-1:0] req1_shamt,
  input  logic [5:0]    req1_funct,
  output logic [DW-1:0] sh_dataA,
  output logic [DW-1:0] sh_dataB,
  output logic [5:0]    sh_signal,
  output logic          sh_reset,
  input  logic [DW-1:0] sh_dataOut,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last_grant;
  logic          r_err;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic [DW-1:0] w_data;
  logic [DW-1:0] w_shamt;
  logic [5:0]    w_funct;
  logic          w_err;
  logic [DW-1:0] w_opnd;
  logic [DW-1:0] w_result;

  // The shifter only ever performs SLL; right shifts are built around it.
  assign sh_signal = FUNCT_SLL;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  assign w_accept = (r_state == S_IDLE) && (w_grant0 || w_grant1);
  assign w_data   = w_grant1 ? req1_data  : req0_data;
  assign w_shamt  = w_grant1 ? req1_shamt : req0_shamt;
  assign w_funct  = w_grant1 ? req1_funct : req0_funct;

`ifdef SHIFT_SRL_EN
  logic          r_rev;
  logic          w_rev;
  logic [DW-1:0] w_data_rev;
  logic [DW-1:0] w_out_rev;

  // SRL is SLL on the mirrored operand, mirrored back on the way out.
  for (genvar i = 0; i < DW; i++) begin : g_rev
    assign w_data_rev[i] = w_data[DW-1-i];
    assign w_out_rev[i]  = sh_dataOut[DW-1-i];
  end

  assign w_rev    = (w_funct == FUNCT_SRL);
  assign w_err    = (w_funct != FUNCT_SLL) && !w_rev;
  assign w_opnd   = w_rev ? w_data_rev : w_data;
  assign w_result = r_rev ? w_out_rev : sh_dataOut;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rev <= 1'b0;
    end else if (w_accept) begin
      r_rev <= w_rev;
    end
  end
`else
  assign w_err    = (w_funct != FUNCT_SLL) || (w_funct == FUNCT_SRL);
  assign w_opnd   = w_data;
  assign w_result = sh_dataOut;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    sh_reset    = 1'b1;
    case (r_state)
      S_IDLE: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        sh_reset    = 1'b0;
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // last_grant doubles as the id of the operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= RR_INIT;
      r_err        <= 1'b0;
      sh_dataA     <= '0;
      sh_dataB     <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant1;
        r_err        <= w_err;
        sh_dataA     <= w_opnd;
        sh_dataB     <= w_shamt;
      end
      if (r_state == S_BUSY) begin
        rsp_valid <= 1'b1;
        rsp_id    <= r_last_grant;
        rsp_err   <= r_err;
        rsp_data  <= r_err ? '0 : w_result;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shifter_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_arbiter_ctrl
// Brief    : Directed + randomized self-checking bench for shifter_arbiter_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_arbiter_ctrl;

  localparam logic [5:0] C_SLL = 6'h00;
  localparam logic [5:0] C_SRL = 6'h02;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req0_shamt, req1_data, req1_shamt;
  logic [5:0]  req0_funct, req1_funct;
  logic [31:0] sh_dataA, sh_dataB, sh_dataOut;
  logic [5:0]  sh_signal;
  logic        sh_reset;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_data;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;
  bit m_last  = 1'b1;

  always #5 clk = ~clk;

  // Behavioural stand-in for the BarrelShifter instance.
  assign sh_dataOut = sh_reset ? 32'h0 :
                      ((|sh_dataB[31:5]) ? 32'h0 : (sh_dataA << sh_dataB[4:0]));

  shifter_arbiter_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_shamt(req0_shamt), .req0_funct(req0_funct),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_shamt(req1_shamt), .req1_funct(req1_funct),
    .sh_dataA(sh_dataA), .sh_dataB(sh_dataB), .sh_signal(sh_signal),
    .sh_reset(sh_reset), .sh_dataOut(sh_dataOut),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] d, input logic [31:0] s,
                                input logic [5:0] f, output logic [31:0] r, output bit e);
    r = 32'h0;
    e = 1'b1;
    if (f == C_SLL) begin
      r = (s >= 32) ? 32'h0 : d << s[4:0];
      e = 1'b0;
    end
`ifdef SHIFT_SRL_EN
    else if (f == C_SRL) begin
      r = (s >= 32) ? 32'h0 : d >> s[4:0];
      e = 1'b0;
    end
`endif
  endfunction

  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] d0, input logic [31:0] s0, input logic [5:0] f0,
                     input logic [31:0] d1, input logic [31:0] s1, input logic [5:0] f1,
                     input int hold);
    bit          win;
    logic [31:0] ed;
    bit          ee;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_shamt = s0; req0_funct = f0;
    req1_valid = v1; req1_data = d1; req1_shamt = s1; req1_funct = f1;
    rsp_ready  = (hold == 0);
    win = (v0 && v1) ? !m_last : v1;
    if (win) model(d1, s1, f1, ed, ee);
    else     model(d0, s0, f0, ed, ee);
    #1;
    chk("idle_req0_ready", req0_ready, !win);
    chk("idle_req1_ready", req1_ready, win);
    @(posedge clk); #1;
    m_last = win;
    req0_valid = 1'b1; req0_data = $urandom; req0_shamt = $urandom; req0_funct = 6'($urandom);
    req1_valid = 1'b1; req1_data = $urandom; req1_shamt = $urandom; req1_funct = 6'($urandom);
    #1;
    chk("busy_sh_reset", sh_reset, 0);
    chk("busy_rsp_valid", rsp_valid, 0);
    chk("busy_ready", {req0_ready, req1_ready}, 0);
    chk("sh_signal", sh_signal, C_SLL);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, win);
    chk("rsp_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    for (int k = 0; k < hold; k++) begin
      req0_data = $urandom; req1_data = $urandom;
      @(posedge clk); #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, ed);
      chk("hold_rsp_id", rsp_id, win);
      chk("hold_rsp_err", rsp_err, ee);
      chk("hold_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rsp_done", rsp_valid, 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_sh_dataA"}, sh_dataA, 0);
    chk({tag, "_sh_dataB"}, sh_dataB, 0);
    chk({tag, "_sh_reset"}, sh_reset, 1);
    chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
  endtask

  initial begin
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_funct = '0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_funct = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("por");
    @(negedge clk);
    reset = 1'b0;

    // Both requesting from reset: expect 0,1,0.
    for (int i = 0; i < 3; i++)
      txn(1, 1, $urandom, 32'($urandom_range(0, 31)), C_SLL,
                $urandom, 32'($urandom_range(0, 31)), C_SLL, 0);

    txn(1, 0, 32'h0000_0001, 32'd4, C_SLL, 32'h0, 32'h0, C_SLL, 0);
    txn(0, 1, 32'h0, 32'h0, C_SLL, 32'hFFFF_FFFF, 32'h0000_0020, C_SLL, 0);
    txn(0, 1, 32'h0, 32'h0, C_SLL, 32'hFFFF_FFFF, 32'd31, C_SLL, 0);
    txn(0, 1, 32'h0, 32'h0, C_SLL, 32'h1234_5678, 32'h8000_0001, C_SLL, 0);
    txn(1, 0, 32'hDEAD_BEEF, 32'd3, 6'h03, 32'h0, 32'h0, C_SLL, 0);
    txn(1, 0, 32'h8000_0000, 32'd4, C_SRL, 32'h0, 32'h0, C_SLL, 0);
    txn(1, 1, 32'hA5A5_0001, 32'd7, C_SLL, 32'h0F0F_0F0F, 32'd12, C_SRL, 5);
    txn(1, 0, 32'h0000_00FF, 32'd8, C_SLL, 32'h0, 32'h0, C_SLL, 0);

    for (int i = 0; i < 40; i++) begin
      bit          v0, v1;
      logic [31:0] s0, s1;
      logic [5:0]  f0, f1;
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      s0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      s1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: f0 = 6'($urandom);
        1: f0 = C_SRL;
        default: f0 = C_SLL;
      endcase
      case ($urandom_range(0, 3))
        0: f1 = 6'($urandom);
        1: f1 = C_SRL;
        default: f1 = C_SLL;
      endcase
      txn(v0, v1, $urandom, s0, f0, $urandom, s1, f1, int'($urandom_range(0, 2)));
    end

    // Leave a non-zero response on the channel, then reset in the middle of BUSY.
    txn(0, 1, 32'h0, 32'h0, C_SLL, 32'h0000_0005, 32'd1, C_SLL, 0);
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 32'h0000_0003; req0_shamt = 32'd3; req0_funct = C_SLL;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("pre_reset_busy", sh_reset, 0);
    #1;
    reset = 1'b1;
    #1;
    chk_reset_values("async");
    @(negedge clk);
    reset = 1'b0;
    m_last = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("no_rsp_after_reset", rsp_valid, 0);
    end
    txn(1, 1, 32'h0000_0003, 32'd3, C_SLL, 32'h1, 32'd1, C_SLL, 0);
    txn(1, 1, 32'h0000_0003, 32'd3, C_SLL, 32'h1, 32'd1, C_SLL, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
